// File: rtl/alu_4bit_if.sv
// Operand/result bundle for the registered ALU.
// Ports: in_valid/a/b/sel flow controller -> ALU; out/carry_out/out_valid flow back.
// No backpressure: the ALU accepts one operation every cycle.
interface alu_4bit_if #(
  parameter int WIDTH = 4
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out;
  logic             carry_out;
  logic             out_valid;

  // Controller side: issues operations, observes registered results.
  modport master (
    output in_valid,
    output a,
    output b,
    output sel,
    input  out,
    input  carry_out,
    input  out_valid
  );

  // ALU side: consumes operations, drives registered results.
  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  sel,
    output out,
    output carry_out,
    output out_valid
  );

endinterface

// File: rtl/alu_4bit.sv
// Registered AND/OR/XOR/ADD unit on two unsigned WIDTH-bit operands.
// Latency 1 cycle, throughput 1 op/cycle; no backpressure (always ready).
// Ports: clk, rst (sync, active-high), bus (slave: in_valid/a/b/sel in, out/carry_out/out_valid out).
module alu_4bit #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  alu_4bit_if.slave  bus
);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  logic [WIDTH-1:0] out_q,   out_d;
  logic             carry_q, carry_d;
  logic             vld_q,   vld_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             res_carry;

  // Opcode decode. The adder is one bit wider so the top bit is the carry.
  always_comb begin
    sum       = {1'b0, bus.a} + {1'b0, bus.b};
    res       = '0;
    res_carry = 1'b0;
    case (bus.sel)
      OP_AND: res = bus.a & bus.b;
      OP_OR:  res = bus.a | bus.b;
      OP_XOR: res = bus.a ^ bus.b;
      OP_ADD: begin
        res       = sum[WIDTH-1:0];
        res_carry = sum[WIDTH];
      end
    endcase
  end

  // Idle cycles keep the last result visible; only the valid flag drops.
  always_comb begin
    out_d   = out_q;
    carry_d = carry_q;
    vld_d   = bus.in_valid;
    if (bus.in_valid) begin
      out_d   = res;
      carry_d = res_carry;
    end
  end

  // Reset wins over in_valid, discarding whatever was being issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      carry_q <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.carry_out = carry_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_alu_4bit.sv
// Bench for alu_4bit: directed sequences then random traffic, scoreboard-checked.
module tb_alu_4bit;

  typedef struct {
    logic [3:0] o;
    logic       c;
  } res_t;

  logic clk;
  logic rst;

  alu_4bit_if #(.WIDTH(4)) bus ();

  alu_4bit #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];

  // Reference state: whether a result is due, and what idle outputs should show.
  logic       exp_vld  = 1'b0;
  logic [3:0] held_o   = 4'h0;
  logic       held_c   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluates the operation as plain integer arithmetic at each edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_vld = 1'b0;
        held_o  = 4'h0;
        held_c  = 1'b0;
      end else if (bus.in_valid) begin
        int   s;
        res_t r;
        case (bus.sel)
          2'd0:    s = int'(bus.a & bus.b);
          2'd1:    s = int'(bus.a | bus.b);
          2'd2:    s = int'(bus.a ^ bus.b);
          default: s = int'(bus.a) + int'(bus.b);
        endcase
        r.o = 4'(s % 16);
        r.c = (s >= 16);
        exp_q.push_back(r);
        exp_vld = 1'b1;
        held_o  = r.o;
        held_c  = r.c;
      end else begin
        exp_vld = 1'b0;
      end
    end
  end

  // Monitor: samples mid-cycle, pops an expected result whenever out_valid is seen.
  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", int'(bus.out_valid), int'(exp_vld));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          res_t r;
          r = exp_q.pop_front();
          chk("out", int'(bus.out), int'(r.o));
          chk("carry_out", int'(bus.carry_out), int'(r.c));
        end
      end else begin
        chk("hold_out", int'(bus.out), int'(held_o));
        chk("hold_carry", int'(bus.carry_out), int'(held_c));
      end
    end
  end

  task automatic step(input logic r, input logic v, input logic [3:0] a,
                      input logic [3:0] b, input logic [1:0] s);
    rst          = r;
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.sel      = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held for two edges while a full-scale ADD is presented.
    step(1'b1, 1'b1, 4'hF, 4'hF, 2'b11);
    step(1'b1, 1'b1, 4'hF, 4'hF, 2'b11);
    // ADD, including wrap with carry.
    step(1'b0, 1'b1, 4'h3, 4'h1, 2'b11);
    step(1'b0, 1'b1, 4'hF, 4'h1, 2'b11);
    step(1'b0, 1'b1, 4'hF, 4'hF, 2'b11);
    // Logic ops back to back.
    step(1'b0, 1'b1, 4'h4, 4'h2, 2'b00);
    step(1'b0, 1'b1, 4'hC, 4'hA, 2'b01);
    step(1'b0, 1'b1, 4'hC, 4'hA, 2'b10);
    // Carry must clear on the following logic op.
    step(1'b0, 1'b1, 4'h8, 4'h8, 2'b11);
    step(1'b0, 1'b1, 4'hF, 4'hF, 2'b00);
    // Result 0110, then three idle cycles with changing inputs.
    step(1'b0, 1'b1, 4'hC, 4'hA, 2'b10);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)));
    // Reset on the same edge as an ADD, then the op completes normally.
    step(1'b1, 1'b1, 4'h7, 4'h1, 2'b11);
    step(1'b0, 1'b1, 4'h7, 4'h1, 2'b11);
    // Random traffic with occasional resets and idle cycles.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)));
    // Drain.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 4'h0, 4'h0, 2'b00);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
